// File: rtl/uart_tx_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_pkg
// Shared definitions for the UART transmit frame controller:
//   - tx_state_e     : frame controller states (STOP2 is only used when the
//                      UART_TX_TWO_STOP_EN macro is defined)
//   - IDLE_LVL, START_LVL, STOP_LVL : serial line levels
//   - DATA_WIDTH_DEF : default number of data bits per frame
// -----------------------------------------------------------------------------
package uart_tx_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      STOP2  = 3'd5
   } tx_state_e;

   localparam logic IDLE_LVL  = 1'b1;
   localparam logic START_LVL = 1'b0;
   localparam logic STOP_LVL  = 1'b1;

   localparam int DATA_WIDTH_DEF = 8;

endpackage : uart_tx_pkg

// File: rtl/uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer
// Data shift register plus data-bit counter for the UART transmitter.
// bit_o always presents the next data bit to send (shift register LSB).
// Ports:
//   clk_i      : baud clock
//   rst_i      : synchronous active-high reset (clears register and counter)
//   load_i     : capture data_i into the shift register
//   data_i     : parallel data word
//   shift_i    : shift the register right by one (zero fill)
//   cnt_inc_i  : advance the data-bit counter
//   cnt_clr_i  : clear the data-bit counter (priority over cnt_inc_i)
//   bit_o      : current LSB of the shift register
//   done_o     : counter has reached the last data bit (DATA_WIDTH-1)
// -----------------------------------------------------------------------------
module uart_tx_serializer
   import uart_tx_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  load_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  shift_i,
   input  logic                  cnt_inc_i,
   input  logic                  cnt_clr_i,
   output logic                  bit_o,
   output logic                  done_o
);

   localparam int CNT_W = $clog2(DATA_WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;

   always_comb begin
      shift_d = shift_q;
      if (load_i) begin
         shift_d = data_i;
      end else if (shift_i) begin
         shift_d = {1'b0, shift_q[DATA_WIDTH-1:1]};
      end

      cnt_d = cnt_q;
      if (cnt_clr_i) begin
         cnt_d = '0;
      end else if (cnt_inc_i) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         shift_q <= '0;
         cnt_q   <= '0;
      end else begin
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bit_o  = shift_q[0];
   assign done_o = (cnt_q == CNT_LAST);

endmodule : uart_tx_serializer

// File: rtl/uart_tx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// uart_tx_frame_ctrl
// UART transmit frame controller: one bit per CLK (baud clock). Frame is
// start bit, DATA_WIDTH data bits LSB first, optional parity bit (taken from
// the external parity calculator), and stop bit(s).
// Optional feature: define UART_TX_TWO_STOP_EN to send two stop bits.
// Ports:
//   CLK        : TX baud clock
//   RST        : synchronous active-high reset, aborts any frame in progress
//   P_DATA     : parallel data, sampled on accept
//   Data_Valid : send request, honoured only in IDLE
//   PAR_EN     : include parity bit, sampled on accept
//   par_bit    : parity from the parity calculator
//   par_ld     : load enable to the parity calculator (combinational)
//   TX_OUT     : serial line, idle high (registered)
//   Busy       : frame in progress (registered)
// -----------------------------------------------------------------------------
module uart_tx_frame_ctrl
   import uart_tx_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  Data_Valid,
   input  logic                  PAR_EN,
   input  logic                  par_bit,
   output logic                  par_ld,
   output logic                  TX_OUT,
   output logic                  Busy
);

   tx_state_e state_q;
   logic      par_en_q;
   logic      tx_q;
   logic      busy_q;

   logic ser_load, ser_shift, ser_cnt_inc, ser_cnt_clr;
   logic ser_bit, ser_done;

   // Serializer control. The shift happens on the same edge that drives the
   // current LSB onto the line, so ser_bit is always the next bit to send.
   always_comb begin
      ser_load    = 1'b0;
      ser_shift   = 1'b0;
      ser_cnt_inc = 1'b0;
      ser_cnt_clr = 1'b0;
      case (state_q)
         IDLE:  ser_load  = Data_Valid;
         START: ser_shift = 1'b1;
         DATA: begin
            if (ser_done) begin
               ser_cnt_clr = 1'b1;
            end else begin
               ser_shift   = 1'b1;
               ser_cnt_inc = 1'b1;
            end
         end
         default: ;
      endcase
   end

   uart_tx_serializer #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_serializer (
      .clk_i     (CLK),
      .rst_i     (RST),
      .load_i    (ser_load),
      .data_i    (P_DATA),
      .shift_i   (ser_shift),
      .cnt_inc_i (ser_cnt_inc),
      .cnt_clr_i (ser_cnt_clr),
      .bit_o     (ser_bit),
      .done_o    (ser_done)
   );

   // Parity calculator captures P_DATA on the same edge as the accept.
   assign par_ld = (state_q == IDLE) & Data_Valid & ~RST;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= IDLE;
         tx_q     <= IDLE_LVL;
         busy_q   <= 1'b0;
         par_en_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (Data_Valid) begin
                  par_en_q <= PAR_EN;
                  state_q  <= START;
                  tx_q     <= START_LVL;
                  busy_q   <= 1'b1;
               end
            end
            START: begin
               state_q <= DATA;
               tx_q    <= ser_bit;
            end
            DATA: begin
               if (ser_done) begin
                  if (par_en_q) begin
                     state_q <= PARITY;
                     tx_q    <= par_bit;
                  end else begin
                     state_q <= STOP;
                     tx_q    <= STOP_LVL;
                  end
               end else begin
                  tx_q <= ser_bit;
               end
            end
            PARITY: begin
               state_q <= STOP;
               tx_q    <= STOP_LVL;
            end
`ifdef UART_TX_TWO_STOP_EN
            STOP: begin
               state_q <= STOP2;
               tx_q    <= STOP_LVL;
            end
            STOP2: begin
               state_q <= IDLE;
               tx_q    <= IDLE_LVL;
               busy_q  <= 1'b0;
            end
`else
            STOP: begin
               state_q <= IDLE;
               tx_q    <= IDLE_LVL;
               busy_q  <= 1'b0;
            end
`endif
            default: begin
               state_q <= IDLE;
               tx_q    <= IDLE_LVL;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign TX_OUT = tx_q;
   assign Busy   = busy_q;

endmodule : uart_tx_frame_ctrl

// File: tb/tb_uart_tx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_frame_ctrl
// Self-checking bench for uart_tx_frame_ctrl. Contains a stand-in parity
// calculator (even/odd selectable) and builds the expected serial frame for
// each transfer as a list of line levels.
// -----------------------------------------------------------------------------
module tb_uart_tx_frame_ctrl;

   localparam int DW = 8;
`ifdef UART_TX_TWO_STOP_EN
   localparam int N_STOP = 2;
`else
   localparam int N_STOP = 1;
`endif

   logic          CLK = 1'b0;
   logic          RST;
   logic [DW-1:0] P_DATA;
   logic          Data_Valid;
   logic          PAR_EN;
   logic          par_bit = 1'b0;
   logic          par_ld;
   logic          TX_OUT;
   logic          Busy;

   logic          odd_mode = 1'b0;
   int            errors = 0;
   int            checks = 0;

   uart_tx_frame_ctrl #(
      .DATA_WIDTH (DW)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .P_DATA     (P_DATA),
      .Data_Valid (Data_Valid),
      .PAR_EN     (PAR_EN),
      .par_bit    (par_bit),
      .par_ld     (par_ld),
      .TX_OUT     (TX_OUT),
      .Busy       (Busy)
   );

   always #5 CLK = ~CLK;

   // Parity calculator stand-in: captures on par_ld, holds otherwise.
   always @(posedge CLK) begin
      if (par_ld) par_bit <= (^P_DATA) ^ odd_mode;
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%b expected=%b at t=%0t", tag, obs, exp, $time);
      end
   endtask

   // Called in an idle cycle (just after an edge). Requests a frame, checks
   // every line slot, and returns in the idle cycle that follows the frame.
   task automatic run_frame(input logic [DW-1:0] d, input logic pe,
                            input logic hold, input logic [DW-1:0] nxt);
      logic exp_q[$];
      logic par_exp;
      chk("pre_idle_tx", TX_OUT, 1'b1);
      chk("pre_idle_busy", Busy, 1'b0);
      P_DATA     = d;
      PAR_EN     = pe;
      Data_Valid = 1'b1;
      #1;
      chk("accept_par_ld", par_ld, 1'b1);

      par_exp = 1'b0;
      for (int i = 0; i < DW; i++) par_exp = par_exp ^ d[i];
      par_exp = par_exp ^ odd_mode;
      exp_q.push_back(1'b0);
      for (int i = 0; i < DW; i++) exp_q.push_back(d[i]);
      if (pe) exp_q.push_back(par_exp);
      for (int i = 0; i < N_STOP; i++) exp_q.push_back(1'b1);

      tick();
      // Inputs changed mid-frame must not disturb the frame in flight.
      if (hold) begin
         P_DATA = nxt;
      end else begin
         Data_Valid = 1'b0;
         P_DATA     = DW'($urandom);
      end
      PAR_EN = 1'($urandom);
      #1;
      foreach (exp_q[i]) begin
         chk($sformatf("tx_slot%0d", i), TX_OUT, exp_q[i]);
         chk($sformatf("busy_slot%0d", i), Busy, 1'b1);
         chk($sformatf("par_ld_slot%0d", i), par_ld, 1'b0);
         tick();
      end
      chk("post_idle_tx", TX_OUT, 1'b1);
      chk("post_idle_busy", Busy, 1'b0);
      chk("post_idle_par_ld", par_ld, hold);
      $display("frame data=%h par_en=%b odd=%b slots=%0d", d, pe, odd_mode, exp_q.size());
   endtask

   initial begin
      logic [DW-1:0] v;
      RST        = 1'b1;
      Data_Valid = 1'b1;
      P_DATA     = '0;
      PAR_EN     = 1'b0;
      #1;
      chk("reset_par_ld", par_ld, 1'b0);
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("reset_tx", TX_OUT, 1'b1);
         chk("reset_busy", Busy, 1'b0);
      end
      Data_Valid = 1'b0;
      RST        = 1'b0;
      #1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("idle_tx", TX_OUT, 1'b1);
         chk("idle_busy", Busy, 1'b0);
         chk("idle_par_ld", par_ld, 1'b0);
      end

      // 0xA5 with parity, even then odd; 0x00 without parity.
      odd_mode = 1'b0;
      run_frame(8'hA5, 1'b1, 1'b0, 8'h00);
      odd_mode = 1'b1;
      run_frame(8'hA5, 1'b1, 1'b0, 8'h00);
      odd_mode = 1'b0;
      run_frame(8'h00, 1'b0, 1'b0, 8'h00);

      // Back-to-back with Data_Valid held high, data changed mid-frame.
      run_frame(8'h5A, 1'b1, 1'b1, 8'h3C);
      run_frame(8'h3C, 1'b1, 1'b0, 8'h00);

      // Reset during data bit 3.
      v          = 8'hA5;
      P_DATA     = v;
      PAR_EN     = 1'b1;
      Data_Valid = 1'b1;
      tick();
      Data_Valid = 1'b0;
      repeat (4) tick();
      chk("mid_data3", TX_OUT, v[3]);
      chk("mid_busy", Busy, 1'b1);
      RST        = 1'b1;
      Data_Valid = 1'b1;
      #1;
      chk("rst_par_ld", par_ld, 1'b0);
      tick();
      chk("abort_tx", TX_OUT, 1'b1);
      chk("abort_busy", Busy, 1'b0);
      RST        = 1'b0;
      Data_Valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("abort_idle_tx", TX_OUT, 1'b1);
         chk("abort_idle_busy", Busy, 1'b0);
      end
      run_frame(8'hFF, 1'b1, 1'b0, 8'h00);

      // Randomized frames.
      for (int n = 0; n < 30; n++) begin
         odd_mode = 1'($urandom);
         run_frame(DW'($urandom), 1'($urandom), 1'b0, 8'h00);
         repeat ($urandom_range(0, 2)) tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_uart_tx_frame_ctrl
